cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_refill.sv | 58 +++++
 rtl/cache_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way read-only cache controller.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int TAG_W    = 22;
    localparam int SET_W    = 6;
    localparam int WAYS     = 2;
    localparam int WAY_W    = 1;
    localparam int LINE_W   = 128;
    localparam int WORDS    = 4;
    localparam int BEAT_W   = 2;
    localparam int BE_W     = LINE_W / 8;
    localparam int NUM_SETS = 1 << SET_W;
    // Flush walks every {set,way} pair once.
    localparam int FLUSH_W  = SET_W + WAY_W;

    // Address field boundaries: tag[31:10], set[9:4], word[3:2].
    localparam int TAG_LSB  = 10;
    localparam int SET_LSB  = 4;
    localparam int WORD_LSB = 2;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_TAG0,
        S_TAG1,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_e;

    // Pick one 32-bit word out of a cache line.
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_W-1:0] idx);
        return line[WORD_W*idx +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_refill.sv
// Refill word collector: issues the four beat requests of a line in
// ascending order and assembles the in-order responses into a line.
module cache_refill
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [SET_W-1:0]  set_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [LINE_W-1:0] line_o,
    output logic              done_o
);

    // Counters are one bit wider than a beat index so "all four done" is bit 2.
    logic [BEAT_W:0]                req_cnt_q, req_cnt_d;
    logic [BEAT_W:0]                rsp_cnt_q, rsp_cnt_d;
    logic [WORDS-1:0][WORD_W-1:0]   line_q, line_d;
    logic                           beat_ok;

    assign mem_req_o  = active_i && !req_cnt_q[BEAT_W];
    assign mem_addr_o = mem_req_o ? {tag_i, set_i, req_cnt_q[BEAT_W-1:0], 2'b00} : '0;
    // Responses only count while a refill is in progress.
    assign beat_ok    = active_i && mem_rvalid_i && !rsp_cnt_q[BEAT_W];
    assign done_o     = beat_ok && (rsp_cnt_q[BEAT_W-1:0] == 2'd3);
    assign line_o     = line_q;

    // Beat counters restart whenever no refill is running; responses land in arrival order.
    always_comb begin
        req_cnt_d = '0;
        rsp_cnt_d = '0;
        line_d    = line_q;
        if (active_i) begin
            req_cnt_d = req_cnt_q + {2'b00, (mem_req_o && mem_gnt_i)};
            rsp_cnt_d = rsp_cnt_q + {2'b00, beat_ok};
        end
        if (beat_ok) line_d[rsp_cnt_q[BEAT_W-1:0]] = mem_rdata_i;
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            line_q    <= '0;
        end else begin
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            line_q    <= line_d;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative read-only cache controller: tag lookup over an
// external synchronous cache memory, line refill and full invalidate.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    // core side
    input  logic              core_req_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [WORD_W-1:0] core_rdata_o,
    // refill side
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    // control
    input  logic              flush_i,
    output logic              busy_o,
    // cache memory
    output logic [SET_W-1:0]  cm_set_o,
    output logic [WAY_W-1:0]  cm_way_o,
    output logic              cm_enable_o,
    output logic              cm_write_enable_o,
    output logic              cm_val_write_enable_o,
    output logic              cm_line_valid_o,
    output logic [TAG_W-1:0]  cm_line_tag_o,
    output logic [LINE_W-1:0] cm_line_o,
    output logic [BE_W-1:0]   cm_line_be_o,
    input  logic [WAYS-1:0]   cm_valid_i,
    input  logic [TAG_W-1:0]  cm_tag_i,
    input  logic [LINE_W-1:0] cm_line_i
);

    localparam state_e RST_STATE = FLUSH_ON_RESET ? S_FLUSH : S_IDLE;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:WORD_LSB]   addr_q, addr_d;
    logic [WORD_W-1:0]          rdata_q, rdata_d;
    logic [WAY_W-1:0]           victim_q, victim_d;
    logic [NUM_SETS-1:0]        repl_q, repl_d;
    logic [FLUSH_W-1:0]         flush_cnt_q, flush_cnt_d;

    logic [TAG_W-1:0]           req_tag;
    logic [SET_W-1:0]           req_set;
    logic [BEAT_W-1:0]          req_word;
    logic                       grant, hit0, hit1;
    logic [WAY_W-1:0]           victim_sel;
    logic                       refill_req, refill_done;
    logic [ADDR_W-1:0]          refill_addr;
    logic [LINE_W-1:0]          refill_line;
    logic                       unused_addr_bits;

    // Byte offset is irrelevant for word access.
    assign unused_addr_bits = ^core_addr_i[WORD_LSB-1:0];

    assign req_tag  = addr_q[ADDR_W-1:TAG_LSB];
    assign req_set  = addr_q[TAG_LSB-1:SET_LSB];
    assign req_word = addr_q[SET_LSB-1:WORD_LSB];

    // A flush request wins over a core request in the same cycle.
    assign grant = (state_q == S_IDLE) && core_req_i && !flush_i;
    // Way0 data arrives in TAG0, way1 data in TAG1; valid bits cover both ways.
    assign hit0  = cm_valid_i[0] && (cm_tag_i == req_tag);
    assign hit1  = cm_valid_i[1] && (cm_tag_i == req_tag);
    // Fill the lowest empty way first, otherwise follow the set's replacement bit.
    assign victim_sel = !cm_valid_i[0] ? 1'b0 :
                        !cm_valid_i[1] ? 1'b1 : repl_q[req_set];

    cache_refill u_refill (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_i     (state_q == S_REFILL),
        .tag_i        (req_tag),
        .set_i        (req_set),
        .mem_req_o    (refill_req),
        .mem_addr_o   (refill_addr),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .line_o       (refill_line),
        .done_o       (refill_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST_STATE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FLUSH:  if (flush_cnt_q == '1) state_d = S_IDLE;
            S_IDLE:   if (flush_i) state_d = S_FLUSH;
                      else if (core_req_i) state_d = S_TAG0;
            S_TAG0:   state_d = hit0 ? S_RESP : S_TAG1;
            S_TAG1:   state_d = hit1 ? S_RESP : S_REFILL;
            S_REFILL: if (refill_done) state_d = S_WRITE;
            S_WRITE:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs per state; everything is held at zero while reset is asserted.
    always_comb begin
        core_gnt_o            = 1'b0;
        core_rvalid_o         = 1'b0;
        core_rdata_o          = '0;
        mem_req_o             = 1'b0;
        mem_addr_o            = '0;
        busy_o                = 1'b0;
        cm_set_o              = '0;
        cm_way_o              = '0;
        cm_enable_o           = 1'b0;
        cm_write_enable_o     = 1'b0;
        cm_val_write_enable_o = 1'b0;
        cm_line_valid_o       = 1'b0;
        cm_line_tag_o         = '0;
        cm_line_o             = '0;
        cm_line_be_o          = '0;
        if (rst_n) begin
            unique case (state_q)
                S_FLUSH: begin
                    busy_o                = 1'b1;
                    cm_enable_o           = 1'b1;
                    cm_val_write_enable_o = 1'b1;
                    cm_set_o              = flush_cnt_q[FLUSH_W-1:WAY_W];
                    cm_way_o              = flush_cnt_q[WAY_W-1:0];
                end
                S_IDLE: begin
                    if (grant) begin
                        core_gnt_o  = 1'b1;
                        cm_enable_o = 1'b1;
                        cm_set_o    = core_addr_i[TAG_LSB-1:SET_LSB];
                    end
                end
                S_TAG0: begin
                    busy_o = 1'b1;
                    if (!hit0) begin
                        cm_enable_o = 1'b1;
                        cm_set_o    = req_set;
                        cm_way_o    = 1'b1;
                    end
                end
                S_TAG1: busy_o = 1'b1;
                S_REFILL: begin
                    busy_o     = 1'b1;
                    mem_req_o  = refill_req;
                    mem_addr_o = refill_addr;
                end
                S_WRITE: begin
                    busy_o                = 1'b1;
                    cm_enable_o           = 1'b1;
                    cm_write_enable_o     = 1'b1;
                    cm_val_write_enable_o = 1'b1;
                    cm_line_valid_o       = 1'b1;
                    cm_line_be_o          = '1;
                    cm_set_o              = req_set;
                    cm_way_o              = victim_q;
                    cm_line_tag_o         = req_tag;
                    cm_line_o             = refill_line;
                end
                S_RESP: begin
                    busy_o        = 1'b1;
                    core_rvalid_o = 1'b1;
                    core_rdata_o  = rdata_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath next-state: request address, response word, victim and replacement bits.
    always_comb begin
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        victim_d    = victim_q;
        repl_d      = repl_q;
        flush_cnt_d = (state_q == S_FLUSH) ? flush_cnt_q + 1'b1 : '0;
        if (grant) addr_d = core_addr_i[ADDR_W-1:WORD_LSB];
        unique case (state_q)
            S_FLUSH: repl_d = '0;
            S_TAG0: begin
                if (hit0) begin
                    rdata_d         = word_sel(cm_line_i, req_word);
                    repl_d[req_set] = 1'b1;
                end
            end
            S_TAG1: begin
                if (hit1) begin
                    rdata_d         = word_sel(cm_line_i, req_word);
                    repl_d[req_set] = 1'b0;
                end else begin
                    victim_d = victim_sel;
                end
            end
            S_WRITE: begin
                rdata_d         = word_sel(refill_line, req_word);
                repl_d[req_set] = ~victim_q;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rdata_q     <= '0;
            victim_q    <= '0;
            repl_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            victim_q    <= victim_d;
            repl_q      <= repl_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
